// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake,
// optional two's-complement mode and divide-by-zero flagging.
module divider_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividiendo,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  dmag_q;
  logic [N-1:0]  dvd_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q_q;
  logic          neg_r_q;
  logic          dz_q;

  logic          dvd_neg_c;
  logic          dsr_neg_c;
  logic [N-1:0]  dvd_mag_c;
  logic [N-1:0]  dsr_mag_c;
  logic [N:0]    shifted_c;
  logic [N:0]    trial_c;
  logic          ge_c;
  logic [N-1:0]  r_d;
  logic [N-1:0]  q_d;
  logic [N-1:0]  q_res_c;
  logic [N-1:0]  r_res_c;
  logic          accept_c;

  // Magnitudes, one restoring step, and final sign fix-up.
  // R < |divisor| keeps the trial inside (-2^N, 2^N), so bit N of the trial is the borrow.
  always_comb begin
    dvd_neg_c = (SIGNED != 0) && dividiendo[N-1];
    dsr_neg_c = (SIGNED != 0) && divisor[N-1];
    dvd_mag_c = dvd_neg_c ? ({N{1'b0}} - dividiendo) : dividiendo;
    dsr_mag_c = dsr_neg_c ? ({N{1'b0}} - divisor) : divisor;
    shifted_c = {r_q, q_q[N-1]};
    trial_c   = shifted_c - {1'b0, dmag_q};
    ge_c      = ~trial_c[N];
    r_d       = ge_c ? trial_c[N-1:0] : shifted_c[N-1:0];
    q_d       = {q_q[N-2:0], ge_c};
    q_res_c   = neg_q_q ? ({N{1'b0}} - q_q) : q_q;
    r_res_c   = neg_r_q ? ({N{1'b0}} - r_q) : r_q;
    accept_c  = start && (state_q != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      q_q       <= '0;
      dmag_q    <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dz_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          div_zero  <= dz_q;
          quotient  <= dz_q ? {N{1'b1}} : q_res_c;
          remainder <= dz_q ? dvd_q : r_res_c;
          state_q   <= S_IDLE;
        end
        default: ;
      endcase
      // Accepted in IDLE and in DONE; overrides the DONE->IDLE move for back-to-back use.
      if (accept_c) begin
        dvd_q   <= dividiendo;
        dz_q    <= (divisor == '0);
        r_q     <= '0;
        q_q     <= dvd_mag_c;
        dmag_q  <= dsr_mag_c;
        cnt_q   <= CW'(N - 1);
        neg_q_q <= dvd_neg_c ^ dsr_neg_c;
        neg_r_q <= dvd_neg_c;
        state_q <= (divisor == '0) ? S_DONE : S_RUN;
        busy    <= (divisor != '0);
      end
    end
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Parametrised sequential restoring divider that produces one quotient bit per clock.
- It is the successor of the shift/compare divider datapath. It generalises operand width, adds an optional signed mode, a start/busy/done handshake and divide-by-zero detection.
- It sits between the operand registers and the result/LED logic of the divider subsystem.

Parameters:
N, 8, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).
SIGNED, 0, 0 selects unsigned division; 1 selects two's-complement division with the quotient truncated toward zero.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  request a division; sampled on the rising edge.
dividiendo  in  N  dividend; captured on the accepted start.
divisor  in  N  divisor; captured on the accepted start.
busy  out  1  high while a division is in progress.
done  out  1  single-cycle pulse; results are valid from this cycle on.
quotient  out  N  quotient result.
remainder  out  N  remainder result.
div_zero  out  1  set with done when the captured divisor was 0.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE. busy, done, div_zero, quotient, remainder are all 0. Reset overrides everything, including a division in flight; the partial result is discarded and no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures both operands.
  - If divisor=0: go to DONE next edge.
  - Otherwise: load the working registers (remainder accumulator R=0, shift register Q=|dividend|, count=N-1), then RUN.
- RUN, one iteration per cycle:
  - Shift {R,Q} left 1.
  - Trial T = R_shifted - |divisor|, computed in N+1 bits.
  - If T >= 0: R=T and Q LSB=1; else R is kept and Q LSB=0.
  - If count=0: go to DONE; else decrement count.
- DONE:
  - done=1 for exactly this one cycle; quotient and remainder are updated in this cycle.
  - Next state is IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back operation).
- busy: 1 in RUN, 0 otherwise.
- start while busy (RUN) is ignored; the operands are not recaptured.
- Latency, nonzero divisor: start accepted at edge k, RUN occupies edges k+1..k+N, done=1 after edge k+N+1.
- Latency, zero divisor: done=1 after edge k+1.
- Result registers hold their values until the next done or reset. div_zero holds until the next done, which rewrites it.
- Divide by zero: quotient = all ones, remainder = dividend (raw input bits), div_zero=1.
- SIGNED=1:
  - Operate on magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - The magnitude of the most negative value is handled in N+1 bits internally.
  - Overflow case (-2^(N-1) / -1): quotient = -2^(N-1) (wraps), remainder = 0, div_zero=0.
- Invariant for nonzero divisor: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.

Test Plan:
1. N=8, SIGNED=0: dividend 8'd203, divisor 8'd5, start for 1 cycle -> busy=1 for 8 cycles; done pulses 9 edges after start; quotient=40, remainder=3, div_zero=0.
2. Divisor 0, dividend 8'hCB -> done 1 cycle after start, busy never high; quotient=8'hFF, remainder=8'hCB, div_zero=1.
3. N=8, SIGNED=1:
   - -7/2 -> quotient=8'hFD (-3), remainder=8'hFF (-1).
   - -128/-1 -> quotient=8'h80, remainder=0.
   - 127/-128 -> quotient=0, remainder=127.
4. Back-to-back: start held across DONE, with new operands 100/7 -> second done exactly 9 edges after the first done; results 14 r 2. A start pulsed mid-RUN with other operands is ignored (first result unchanged).
5. Reset mid-operation: rst=1 at the 4th RUN cycle -> the next cycle shows busy=0, done=0, quotient=0, remainder=0. No done follows. A new start after release gives the correct result.
6. N=16, SIGNED=0: 65535/255 -> quotient=257, remainder=0 after 17 edges. Run a random sweep of 1000 operand pairs checked against the invariant.
